inst_fetch_buf: RTL and testbench

INST_FETCH_BUF -- requirements
Module: inst_fetch_buf

---
 rtl/inst_fetch_buf_if.sv | 12 +
 rtl/inst_fetch_buf.sv | 76 +++++++
 tb/tb_inst_fetch_buf.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_buf_if.sv
// inst_bus: fetch-stage request/response bundle between the pipeline and the fetch buffer
interface inst_bus;
  logic [63:0] addr;
  logic        en;
  logic        ready;
  logic        fence_i;
  logic        valid;
  logic [31:0] rdata;
  logic        acc_err;
  modport slave  (input addr, en, ready, fence_i, output valid, rdata, acc_err);
  modport master (output addr, en, ready, fence_i, input valid, rdata, acc_err);
endinterface

// File: rtl/inst_fetch_buf.sv
// inst_fetch_buf: one-line (8-byte) instruction buffer that serves fetches and refills from memory on a miss
module inst_fetch_buf (
  input  logic          clock,
  input  logic          reset,
  inst_bus.slave        i_bus,
  output logic          mem_req,
  output logic [63:0]   mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [63:0]   mem_rdata,
  input  logic          mem_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t      state, state_n;
  logic        p_vld;
  logic [63:0] p_addr;
  logic        buf_vld;
  logic [60:0] buf_tag;
  logic [63:0] buf_data;
  logic        buf_err;
  logic        hit, accept, fill, miss;
  assign hit           = p_vld && buf_vld && buf_tag == p_addr[63:3];
  assign i_bus.valid   = hit && state == IDLE;
  assign i_bus.rdata   = p_addr[2] ? buf_data[63:32] : buf_data[31:0];
  assign i_bus.acc_err = i_bus.valid && buf_err;
  assign accept        = i_bus.ready && (!p_vld || i_bus.valid);
  assign fill          = state == WAIT && mem_rvalid;
  assign miss          = state == IDLE && p_vld && !hit;
  assign mem_req       = state == REQ;
  // pending fetch address advances only when the fetch stage accepts
  always_ff @(posedge clock) begin
    if (reset) begin
      p_vld  <= 1'b0;
      p_addr <= '0;
    end else if (accept) begin
      p_vld  <= i_bus.en;
      p_addr <= i_bus.addr;
    end
  end
  // line buffer: refill on response, drop on fence or after handing out a faulting line
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_vld  <= 1'b0;
      buf_tag  <= '0;
      buf_data <= '0;
      buf_err  <= 1'b0;
    end else if (fill) begin
      buf_vld  <= 1'b1;
      buf_tag  <= p_addr[63:3];
      buf_data <= mem_rdata;
      buf_err  <= mem_err;
    end else if (accept && (i_bus.fence_i || (i_bus.valid && buf_err))) begin
      buf_vld  <= 1'b0;
    end
  end
  // line address is latched when a miss launches and held afterwards
  always_ff @(posedge clock) begin
    if (reset) mem_addr <= '0;
    else if (miss) mem_addr <= {p_addr[63:3], 3'b000};
  end
  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // next-state: miss -> request -> wait for the single response beat
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = miss ? REQ : IDLE;
      REQ:     state_n = mem_gnt ? WAIT : REQ;
      WAIT:    state_n = mem_rvalid ? IDLE : WAIT;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_inst_fetch_buf.sv
// tb_inst_fetch_buf: directed self-checking bench for the instruction fetch buffer
module tb_inst_fetch_buf;
  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_err;
  int          n_checks = 0;
  int          n_fail = 0;
  inst_bus bus ();
  inst_fetch_buf dut (
    .clock(clock), .reset(reset), .i_bus(bus.slave),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (!reset && dut.fill && dut.accept) begin
      n_fail++;
      $display("FAIL fill_accept_overlap: fill=%0b accept=%0b, required not both", dut.fill, dut.accept);
    end
  end
  task automatic tick();
    @(negedge clock);
  endtask
  task automatic drive(input logic [63:0] a, input logic en, input logic rdy, input logic fence);
    bus.addr = a;
    bus.en = en;
    bus.ready = rdy;
    bus.fence_i = fence;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    drive(64'h0, 1'b0, 1'b0, 1'b0);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    n_checks++; if (bus.acc_err !== 1'b0) begin n_fail++; $display("FAIL reset_acc_err: got %b want 0", bus.acc_err); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_checks++; if (mem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
  endtask
  task automatic test_cold_miss();
    drive(64'h8000_0000, 1'b1, 1'b1, 1'b0);
    tick();
    bus.ready = 1'b0;
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL cold_valid_early: got %b want 0", bus.valid); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL cold_req_early: got %b want 0", mem_req); end
    tick();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL cold_req: got %b want 1", mem_req); end
    n_checks++; if (mem_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL cold_addr: got %h want 80000000", mem_addr); end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL cold_req_after_gnt: got %b want 0", mem_req); end
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL cold_valid_wait: got %b want 0", bus.valid); end
    mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL cold_valid: got %b want 1", bus.valid); end
    n_checks++; if (bus.rdata !== 32'h3333_4444) begin n_fail++; $display("FAIL cold_rdata: got %h want 33334444", bus.rdata); end
    n_checks++; if (bus.acc_err !== 1'b0) begin n_fail++; $display("FAIL cold_acc_err: got %b want 0", bus.acc_err); end
  endtask
  task automatic test_hit();
    drive(64'h8000_0004, 1'b1, 1'b1, 1'b0);
    tick();
    bus.ready = 1'b0;
    n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL hit_valid: got %b want 1", bus.valid); end
    n_checks++; if (bus.rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL hit_rdata: got %h want 11112222", bus.rdata); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hit_mem_req: got %b want 0", mem_req); end
  endtask
  task automatic test_back_pressure();
    drive(64'hDEAD_0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.valid); end
      n_checks++; if (bus.rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL bp_rdata[%0d]: got %h want 11112222", i, bus.rdata); end
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_mem_req[%0d]: got %b want 0", i, mem_req); end
    end
    drive(64'h8000_0000, 1'b0, 1'b1, 1'b0);
    tick();
    bus.ready = 1'b0;
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL bp_en0_valid: got %b want 0", bus.valid); end
    tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_en0_req: got %b want 0", mem_req); end
  endtask
  task automatic test_fence();
    drive(64'h8000_0000, 1'b1, 1'b1, 1'b1);
    tick();
    bus.ready = 1'b0; bus.fence_i = 1'b0;
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL fence_valid: got %b want 0", bus.valid); end
    tick();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL fence_req: got %b want 1", mem_req); end
    n_checks++; if (mem_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL fence_addr: got %h want 80000000", mem_addr); end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    mem_rvalid = 1'b0;
    n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL fence_valid_fill: got %b want 1", bus.valid); end
    n_checks++; if (bus.rdata !== 32'hCCCC_DDDD) begin n_fail++; $display("FAIL fence_rdata: got %h want ccccdddd", bus.rdata); end
  endtask
  task automatic test_fault();
    drive(64'h9000_0000, 1'b1, 1'b1, 1'b0);
    tick();
    bus.ready = 1'b0;
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL fault_miss_valid: got %b want 0", bus.valid); end
    tick();
    n_checks++; if (mem_addr !== 64'h9000_0000) begin n_fail++; $display("FAIL fault_addr: got %h want 90000000", mem_addr); end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
    tick();
    mem_rvalid = 1'b0; mem_err = 1'b0;
    n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL fault_valid: got %b want 1", bus.valid); end
    n_checks++; if (bus.acc_err !== 1'b1) begin n_fail++; $display("FAIL fault_acc_err: got %b want 1", bus.acc_err); end
    drive(64'h9000_0004, 1'b1, 1'b1, 1'b0);
    tick();
    bus.ready = 1'b0;
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL fault_refetch_valid: got %b want 0", bus.valid); end
    tick();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL fault_refetch_req: got %b want 1", mem_req); end
    n_checks++; if (mem_addr !== 64'h9000_0000) begin n_fail++; $display("FAIL fault_refetch_addr: got %h want 90000000", mem_addr); end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h6666_7777_8888_9999;
    tick();
    mem_rvalid = 1'b0;
    n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL fault_refill_valid: got %b want 1", bus.valid); end
    n_checks++; if (bus.rdata !== 32'h6666_7777) begin n_fail++; $display("FAIL fault_refill_rdata: got %h want 66667777", bus.rdata); end
    n_checks++; if (bus.acc_err !== 1'b0) begin n_fail++; $display("FAIL fault_refill_acc_err: got %b want 0", bus.acc_err); end
  endtask
  task automatic test_reset_mid_wait();
    drive(64'hA000_0000, 1'b1, 1'b1, 1'b0);
    tick();
    bus.ready = 1'b0;
    tick();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_wait_req: got %b want 1", mem_req); end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    tick();
    mem_rvalid = 1'b0;
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL rst_wait_valid: got %b want 0", bus.valid); end
    n_checks++; if (dut.buf_vld !== 1'b0) begin n_fail++; $display("FAIL rst_wait_buf_vld: got %b want 0", dut.buf_vld); end
    n_checks++; if (dut.state !== 2'd0) begin n_fail++; $display("FAIL rst_wait_state: got %0d want 0 (IDLE)", dut.state); end
    tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_wait_mem_req: got %b want 0", mem_req); end
  endtask
  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_pressure();
    test_fence();
    test_fault();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
